// File: rtl/a_input_debounce.sv
// Input conditioner for the control FSM's A line: synchronises raw_in, filters
// bounce with a stable-cycle counter, and reports edges and rejected glitches.
module a_input_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       raw_in,
    output logic       A,
    output logic       A_rise,
    output logic       A_fall,
    output logic [7:0] glitch_cnt,
    output logic [1:0] dbg_state
);

    localparam int unsigned GLITCH_W = 8;
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;
    localparam bit                  SINGLE     = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        ST_LOW     = 2'b00,
        ST_WAIT_HI = 2'b01,
        ST_HIGH    = 2'b10,
        ST_WAIT_LO = 2'b11
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [GLITCH_W-1:0]    glitch_q, glitch_d;
    logic                   a_q, a_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Metastability synchroniser; s is the last stage.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // State and registered outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_LOW;
            cnt_q    <= '0;
            glitch_q <= '0;
            a_q      <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            glitch_q <= glitch_d;
            a_q      <= a_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    // Next-state logic; pulses default low so each lasts exactly one cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        glitch_d = glitch_q;
        a_d      = a_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;

        unique case (state_q)
            ST_LOW: begin
                if (s) begin
                    if (SINGLE) begin
                        state_d = ST_HIGH;
                        a_d     = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT_HI;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_WAIT_HI: begin
                if (!s) begin
                    state_d  = ST_LOW;
                    cnt_d    = '0;
                    glitch_d = (glitch_q == GLITCH_MAX) ? glitch_q : glitch_q + GLITCH_W'(1);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    a_d     = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (!s) begin
                    if (SINGLE) begin
                        state_d = ST_LOW;
                        a_d     = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT_LO;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_WAIT_LO: begin
                if (s) begin
                    state_d  = ST_HIGH;
                    cnt_d    = '0;
                    glitch_d = (glitch_q == GLITCH_MAX) ? glitch_q : glitch_q + GLITCH_W'(1);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    a_d     = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
                a_d     = 1'b0;
            end
        endcase
    end

    assign A          = a_q;
    assign A_rise     = rise_q;
    assign A_fall     = fall_q;
    assign glitch_cnt = glitch_q;
    assign dbg_state  = state_q;

endmodule
